multicycle_ctrl: RTL and testbench

Parametrised multicycle MIPS control unit driving the shared datapath: program counter (PC), instruction register (IR), register file, A/B/ALUOut/MDR registers, ALU and memory. It supports R-type ADD/SUB/AND/XOR/NOP/BREAK, LW, SW, BEQ, BNE and J. Memory latency is configurable through a wait-cycle parameter. An optional arithmetic-overflow trap is included.

---
 rtl/multicycle_ctrl_pkg.sv | 167 ++++++++++++++++
 rtl/multicycle_ctrl_mem_wait_counter.sv | 37 +++
 rtl/multicycle_ctrl.sv | 145 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcode and funct
// encodings, FSM state encoding, datapath mux/ALU select encodings, the
// exception vector, and the per-state control-word decode.
package multicycle_ctrl_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2b
   } opcode_e;

   typedef enum logic [5:0] {
      FN_NOP   = 6'h00,
      FN_BREAK = 6'h0d,
      FN_ADD   = 6'h20,
      FN_SUB   = 6'h22,
      FN_AND   = 6'h24,
      FN_XOR   = 6'h26
   } funct_e;

   typedef enum logic [3:0] {
      S_RESET       = 4'd0,
      S_FETCH       = 4'd1,
      S_FETCH_LATCH = 4'd2,
      S_DECODE      = 4'd3,
      S_MEM_ADDR    = 4'd4,
      S_LW_READ     = 4'd5,
      S_LW_LATCH    = 4'd6,
      S_WRITE_BACK  = 4'd7,
      S_SW_WRITE    = 4'd8,
      S_R_EXEC      = 4'd9,
      S_R_WB        = 4'd10,
      S_BRANCH      = 4'd11,
      S_JUMP        = 4'd12,
      S_HALT        = 4'd13,
      S_OVF_TRAP    = 4'd14
   } state_e;

   typedef enum logic [2:0] {
      ALU_PASS_A = 3'b000,
      ALU_ADD    = 3'b001,
      ALU_SUB    = 3'b010,
      ALU_AND    = 3'b011,
      ALU_XOR    = 3'b110
   } alu_sel_e;

   typedef enum logic [1:0] {
      SRCB_B      = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_IMM_SH = 2'b11
   } alu_src_b_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_EXC    = 2'b11
   } pc_source_e;

   // Target the datapath loads when PCSource selects the exception vector.
   localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

   // One registered control word; everything except PC_load lives here.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       wr;
      logic       iord;
      logic       ir_write;
      logic       reg_write;
      logic       a_load;
      logic       b_load;
      logic       mdr_load;
      logic       aluout_load;
      logic       dp_reset;
      alu_sel_e   alu_sel;
      logic       alu_src_a;
      alu_src_b_e alu_src_b;
      pc_source_e pc_source;
      logic       mem_to_reg;
      logic       reg_dst;
   } ctrl_t;

   function automatic alu_sel_e funct_alu(input logic [5:0] funct);
      case (funct)
         FN_ADD:  return ALU_ADD;
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_XOR:  return ALU_XOR;
         default: return ALU_PASS_A;
      endcase
   endfunction

   // Control word for a given state; funct only matters in R_EXEC.
   function automatic ctrl_t decode_ctrl(input state_e st, input logic [5:0] funct);
      ctrl_t c;
      c = '0;
      case (st)
         S_RESET:       c.dp_reset = 1'b1;
         S_FETCH_LATCH: begin
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_sel   = ALU_ADD;
            c.pc_source = PCSRC_ALU;
         end
         S_DECODE: begin
            c.a_load      = 1'b1;
            c.b_load      = 1'b1;
            c.aluout_load = 1'b1;
            c.alu_src_b   = SRCB_IMM_SH;
            c.alu_sel     = ALU_ADD;
         end
         S_MEM_ADDR: begin
            c.alu_src_a   = 1'b1;
            c.alu_src_b   = SRCB_IMM;
            c.alu_sel     = ALU_ADD;
            c.aluout_load = 1'b1;
         end
         S_LW_READ:     c.iord = 1'b1;
         S_LW_LATCH: begin
            c.iord     = 1'b1;
            c.mdr_load = 1'b1;
         end
         S_WRITE_BACK: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_SW_WRITE: begin
            c.iord = 1'b1;
            c.wr   = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a   = 1'b1;
            c.alu_src_b   = SRCB_B;
            c.alu_sel     = funct_alu(funct);
            c.aluout_load = 1'b1;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_B;
            c.alu_sel       = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
         end
         S_OVF_TRAP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_EXC;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_counter.sv
// Memory wait-state counter. Loads MEM_WAIT when a memory-access state is
// entered, counts down to zero and holds there; done is high at zero.
// Ports: Clk, Reset_signal (sync, active-high), load, done.
module mem_wait_counter #(
   parameter int MEM_WAIT = 2
) (
   input  logic Clk,
   input  logic Reset_signal,
   input  logic load,
   output logic done
);

   localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_WAIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = LOAD_VAL;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge Clk) begin
      if (Reset_signal)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit (Moore FSM) for a shared PC/IR/regfile/ALU/
// memory datapath. Supports ADD/SUB/AND/XOR/NOP/BREAK, LW, SW, BEQ, BNE, J.
// Ports: Clk, Reset_signal (sync, active-high), Op/Funct from IR,
//   ALU_zero/ALU_overflow from the ALU, StateOut (zero-extended state),
//   PC/memory/register load strobes and datapath mux selects.
// Optional feature: define MULTICYCLE_CTRL_OVF_TRAP_EN to trap signed
//   overflow of ADD/SUB into OVF_TRAP (PC <- exception vector).
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 2,
   parameter int STATE_W  = 8
) (
   input  logic               Clk,
   input  logic               Reset_signal,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               ALU_zero,
   input  logic               ALU_overflow,
   output logic [STATE_W-1:0] StateOut,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               PC_load,
   output logic               wr,
   output logic               IorD,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               A_load,
   output logic               B_load,
   output logic               MDR_load,
   output logic               ALUOut_load,
   output logic               Dp_reset,
   output logic [2:0]         ALU_sel,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic               MemtoReg,
   output logic               RegDst
);

   state_e state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   is_bne_q, is_bne_d;
   logic   wait_done;
   logic   wait_load;

   always_comb begin
      state_d  = state_q;
      is_bne_d = is_bne_q;
      unique case (state_q)
         S_RESET:       state_d = S_FETCH;
         S_FETCH:       if (wait_done) state_d = S_FETCH_LATCH;
         S_FETCH_LATCH: state_d = S_DECODE;
         S_DECODE: begin
            is_bne_d = (Op == OP_BNE);
            case (Op)
               OP_LW, OP_SW:   state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:           state_d = S_JUMP;
               OP_RTYPE: begin
                  case (Funct)
                     FN_ADD, FN_SUB, FN_AND, FN_XOR: state_d = S_R_EXEC;
                     FN_BREAK:                       state_d = S_HALT;
                     default:                        state_d = S_FETCH;
                  endcase
               end
               default:        state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR:    state_d = (Op == OP_LW) ? S_LW_READ : S_SW_WRITE;
         S_LW_READ:     if (wait_done) state_d = S_LW_LATCH;
         S_LW_LATCH:    state_d = S_WRITE_BACK;
         S_WRITE_BACK:  state_d = S_FETCH;
         S_SW_WRITE:    if (wait_done) state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_OVF_TRAP_EN
         S_R_EXEC:      state_d = (ALU_overflow && (Funct == FN_ADD || Funct == FN_SUB))
                                  ? S_OVF_TRAP : S_R_WB;
`else
         S_R_EXEC:      state_d = S_R_WB;
`endif
         S_R_WB:        state_d = S_FETCH;
         S_BRANCH:      state_d = S_FETCH;
         S_JUMP:        state_d = S_FETCH;
         S_HALT:        state_d = S_HALT;
         S_OVF_TRAP:    state_d = S_FETCH;
         default:       state_d = S_FETCH;
      endcase

      // Outputs are registered alongside the state, so they are decoded from
      // the next state; IR (and thus Funct) is stable well before R_EXEC.
      ctrl_d = decode_ctrl(state_d, Funct);

      // Arm the wait counter only on entry, so each access is held MEM_WAIT+1 cycles.
      wait_load = (state_d != state_q) &&
                  (state_d inside {S_FETCH, S_LW_READ, S_SW_WRITE});
   end

`ifndef MULTICYCLE_CTRL_OVF_TRAP_EN
   logic unused_ovf;
   assign unused_ovf = ALU_overflow;
`endif

   // NOTE: reset forces the state, control word and branch flag; every
   // register here must come up defined because the datapath acts on them.
   always_ff @(posedge Clk) begin
      if (Reset_signal) begin
         state_q  <= S_RESET;
         ctrl_q   <= decode_ctrl(S_RESET, 6'h00);
         is_bne_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         is_bne_q <= is_bne_d;
      end
   end

   mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
      .Clk          (Clk),
      .Reset_signal (Reset_signal),
      .load         (wait_load),
      .done         (wait_done)
   );

   assign StateOut    = STATE_W'(state_q);
   assign PCWrite     = ctrl_q.pc_write;
   assign PCWriteCond = ctrl_q.pc_write_cond;
   // Branch decision needs the live ALU_zero of the BRANCH cycle.
   assign PC_load     = ctrl_q.pc_write | (ctrl_q.pc_write_cond & (ALU_zero ^ is_bne_q));
   assign wr          = ctrl_q.wr;
   assign IorD        = ctrl_q.iord;
   assign IRWrite     = ctrl_q.ir_write;
   assign RegWrite    = ctrl_q.reg_write;
   assign A_load      = ctrl_q.a_load;
   assign B_load      = ctrl_q.b_load;
   assign MDR_load    = ctrl_q.mdr_load;
   assign ALUOut_load = ctrl_q.aluout_load;
   assign Dp_reset    = ctrl_q.dp_reset;
   assign ALU_sel     = ctrl_q.alu_sel;
   assign ALUSrcA     = ctrl_q.alu_src_a;
   assign ALUSrcB     = ctrl_q.alu_src_b;
   assign PCSource    = ctrl_q.pc_source;
   assign MemtoReg    = ctrl_q.mem_to_reg;
   assign RegDst      = ctrl_q.reg_dst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instance 0 at MEM_WAIT=2, instance 1 at
// MEM_WAIT=0. Directed instructions are issued with a hand-written state
// trace (one hex digit per cycle); expected per-cycle outputs are queued and
// a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst  [2] = '{1'b0, 1'b0};
   logic [5:0] op   [2] = '{6'h00, 6'h00};
   logic [5:0] fn   [2] = '{6'h00, 6'h00};
   logic       zero [2] = '{1'b0, 1'b0};
   logic       ovf  [2] = '{1'b0, 1'b0};
   logic [7:0]  act_st  [2];
   logic [21:0] act_out [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [7:0] so;
      logic pcw, pcwc, pcl, w, iord, irw, rw, al, bl, mdr, aol, dpr, sa, m2r, rd;
      logic [2:0] sel;
      logic [1:0] sb, ps;
      multicycle_ctrl #(.MEM_WAIT(g == 0 ? 2 : 0), .STATE_W(8)) u_dut (
         .Clk(clk), .Reset_signal(rst[g]), .Op(op[g]), .Funct(fn[g]),
         .ALU_zero(zero[g]), .ALU_overflow(ovf[g]), .StateOut(so),
         .PCWrite(pcw), .PCWriteCond(pcwc), .PC_load(pcl), .wr(w), .IorD(iord),
         .IRWrite(irw), .RegWrite(rw), .A_load(al), .B_load(bl), .MDR_load(mdr),
         .ALUOut_load(aol), .Dp_reset(dpr), .ALU_sel(sel), .ALUSrcA(sa),
         .ALUSrcB(sb), .PCSource(ps), .MemtoReg(m2r), .RegDst(rd)
      );
      assign act_st[g]  = so;
      assign act_out[g] = {pcw, pcwc, pcl, w, iord, irw, rw, al, bl, mdr, aol, dpr,
                           sel, sa, sb, ps, m2r, rd};
   end

   typedef struct {
      int          cyc;
      logic [3:0]  st;
      logic [21:0] outs;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int d, input int c,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, d, c, act, exp);
      end
   endtask

   // Expected control word per state, written straight from the state table.
   function automatic logic [21:0] exp_outs(input logic [3:0] st, input logic [5:0] f,
                                            input logic z, input logic bne);
      logic pcw, pcwc, pcl, w, iord, irw, rw, al, bl, mdr, aol, dpr, sa, m2r, rd;
      logic [2:0] sel;
      logic [1:0] sb, ps;
      {pcw, pcwc, w, iord, irw, rw, al, bl, mdr, aol, dpr, sa, m2r, rd} = '0;
      sel = 3'b000; sb = 2'b00; ps = 2'b00;
      case (st)
         4'd0:  dpr = 1'b1;
         4'd2:  begin irw = 1'b1; pcw = 1'b1; sb = 2'b01; sel = 3'b001; end
         4'd3:  begin al = 1'b1; bl = 1'b1; aol = 1'b1; sb = 2'b11; sel = 3'b001; end
         4'd4:  begin sa = 1'b1; sb = 2'b10; sel = 3'b001; aol = 1'b1; end
         4'd5:  iord = 1'b1;
         4'd6:  begin iord = 1'b1; mdr = 1'b1; end
         4'd7:  begin rw = 1'b1; m2r = 1'b1; end
         4'd8:  begin iord = 1'b1; w = 1'b1; end
         4'd9:  begin
            sa = 1'b1; aol = 1'b1;
            case (f)
               6'h20:   sel = 3'b001;
               6'h22:   sel = 3'b010;
               6'h24:   sel = 3'b011;
               6'h26:   sel = 3'b110;
               default: sel = 3'b000;
            endcase
         end
         4'd10: begin rw = 1'b1; rd = 1'b1; end
         4'd11: begin sa = 1'b1; sel = 3'b010; pcwc = 1'b1; ps = 2'b01; end
         4'd12: begin pcw = 1'b1; ps = 2'b10; end
         4'd14: begin pcw = 1'b1; ps = 2'b11; end
         default: ;
      endcase
      pcl = pcw | (pcwc & (z ^ bne));
      return {pcw, pcwc, pcl, w, iord, irw, rw, al, bl, mdr, aol, dpr, sel, sa, sb, ps, m2r, rd};
   endfunction

   function automatic logic [3:0] hexc(input byte ch);
      if (ch >= 8'h61) return 4'(ch - 8'h57);
      return 4'(ch - 8'h30);
   endfunction

   task automatic push(input int d, input exp_t e);
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic run(input int d, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic v, input string seq, inout int start);
      exp_t e;
      wait_until(start);
      op[d] = o; fn[d] = f; zero[d] = z; ovf[d] = v;
      for (int i = 0; i < seq.len(); i++) begin
         e.cyc  = start + i;
         e.st   = hexc(seq[i]);
         e.outs = exp_outs(e.st, f, z, o == 6'h05);
         push(d, e);
      end
      start += seq.len();
      wait_until(start);
   endtask

   // Reset asserted during cycle 'start'; RESET is expected for the n cycles
   // after it and FETCH resumes the cycle after deassertion.
   task automatic do_reset(input int d, input int n, inout int start);
      exp_t e;
      wait_until(start);
      rst[d] = 1'b1;
      for (int i = 1; i <= n; i++) begin
         e.cyc  = start + i;
         e.st   = 4'd0;
         e.outs = exp_outs(4'd0, 6'h00, 1'b0, 1'b0);
         push(d, e);
      end
      start += n;
      wait_until(start);
      rst[d] = 1'b0;
      start += 1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb0.size() > 0 && sb0[0].cyc <= cyc) begin
         e = sb0.pop_front();
         if (e.cyc < cyc) check("late_entry", 0, cyc, 32'(cyc), 32'(e.cyc));
         else begin
            check($sformatf("state_s%0d", e.st), 0, cyc, 32'(act_st[0]), 32'(e.st));
            check($sformatf("outs_s%0d", e.st), 0, cyc, 32'(act_out[0]), 32'(e.outs));
         end
      end
      while (sb1.size() > 0 && sb1[0].cyc <= cyc) begin
         e = sb1.pop_front();
         if (e.cyc < cyc) check("late_entry", 1, cyc, 32'(cyc), 32'(e.cyc));
         else begin
            check($sformatf("state_s%0d", e.st), 1, cyc, 32'(act_st[1]), 32'(e.st));
            check($sformatf("outs_s%0d", e.st), 1, cyc, 32'(act_out[1]), 32'(e.outs));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      string add_ovf_seq;
      string sub_ovf_seq;
`ifdef MULTICYCLE_CTRL_OVF_TRAP_EN
      add_ovf_seq = "111239e";
      sub_ovf_seq = "111239e";
`else
      add_ovf_seq = "111239a";
      sub_ovf_seq = "111239a";
`endif
      fork
         begin : seq_w2
            int s = 1;
            do_reset(0, 2, s);
            run(0, 6'h23, 6'h00, 1'b0, 1'b0, "11123455567", s);   // LW, 2W+7
            run(0, 6'h2b, 6'h00, 1'b0, 1'b0, "11123488", s);      // SW, cut short
            do_reset(0, 1, s);                                     // reset mid-SW_WRITE
            run(0, 6'h00, 6'h20, 1'b0, 1'b1, add_ovf_seq, s);      // ADD overflow
            run(0, 6'h00, 6'h22, 1'b0, 1'b1, sub_ovf_seq, s);      // SUB overflow
            run(0, 6'h00, 6'h22, 1'b0, 1'b0, "111239a", s);        // SUB
            run(0, 6'h00, 6'h24, 1'b0, 1'b1, "111239a", s);        // AND never traps
            run(0, 6'h00, 6'h26, 1'b0, 1'b0, "111239a", s);        // XOR
            run(0, 6'h04, 6'h00, 1'b1, 1'b0, "11123b", s);         // BEQ taken
            run(0, 6'h04, 6'h00, 1'b0, 1'b0, "11123b", s);         // BEQ not taken
            run(0, 6'h05, 6'h00, 1'b1, 1'b0, "11123b", s);         // BNE not taken
            run(0, 6'h05, 6'h00, 1'b0, 1'b0, "11123b", s);         // BNE taken
            run(0, 6'h02, 6'h00, 1'b0, 1'b0, "11123c", s);         // J
            run(0, 6'h00, 6'h00, 1'b0, 1'b0, "11123", s);          // NOP
            run(0, 6'h00, 6'h3f, 1'b0, 1'b0, "11123", s);          // unknown funct
            run(0, 6'h00, 6'h0d, 1'b0, 1'b0, "11123dddddddddddddddddddd", s); // BREAK
            do_reset(0, 1, s);                                     // leaves HALT
            run(0, 6'h02, 6'h00, 1'b0, 1'b0, "11123c", s);         // J after recovery
         end
         begin : seq_w0
            int s = 1;
            do_reset(1, 1, s);
            run(1, 6'h02, 6'h00, 1'b0, 1'b0, "123c", s);           // J in 4 cycles
            run(1, 6'h3f, 6'h00, 1'b0, 1'b0, "123", s);            // unknown Op
            run(1, 6'h23, 6'h00, 1'b0, 1'b0, "1234567", s);        // LW, 7 cycles
            run(1, 6'h2b, 6'h00, 1'b0, 1'b0, "12348", s);          // SW, 5 cycles
            run(1, 6'h04, 6'h00, 1'b0, 1'b0, "123b", s);           // BEQ not taken
            run(1, 6'h00, 6'h20, 1'b0, 1'b0, "1239a", s);          // ADD, 5 cycles
         end
      join
      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", 0, cyc, 32'(sb0.size() + sb1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
